// File: rtl/ysyx_24100005_mem_arbiter.sv
// ysyx_24100005_mem_arbiter
// Shares the single data-memory bridge port between the IFU and the LSU.
// One transaction in flight at a time: IDLE grants a requester, ISSUE holds a
// valid/ready request toward the bridge, WAIT collects the response (or times
// out), RESP returns a one-cycle pulse to the requester that owns the slot.
module ysyx_24100005_mem_arbiter #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_resp_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;
    // The timer starts at 0 in the first ISSUE cycle, so reaching this value
    // marks the last of 2^TIMEOUT_W - 1 cycles spent without a response.
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

    state_t               state_r;
    state_t               state_s;
    logic                 last_grant_r;
    logic                 owner_r;
    logic [TIMEOUT_W-1:0] timer_r;
    logic [31:0]          addr_r;
    logic                 wen_r;
    logic [31:0]          wdata_r;
    logic [7:0]           wmask_r;
    logic [31:0]          rdata_r;
    logic                 err_r;

    logic                 grant_ifu_s;
    logic                 grant_lsu_s;
    logic                 accept_s;
    logic                 busy_s;
    logic                 timeout_s;
    logic                 resp_hit_s;

    // Grant selection in IDLE: lone requester wins, a tie goes to whoever was not granted last.
    always_comb begin
        grant_ifu_s = 1'b0;
        grant_lsu_s = 1'b0;
        if ((state_r == ST_IDLE) && !rst) begin
            if (lsu_req_valid && (!ifu_req_valid || (last_grant_r == OWNER_IFU))) begin
                grant_lsu_s = 1'b1;
            end else if (ifu_req_valid) begin
                grant_ifu_s = 1'b1;
            end else begin
                grant_ifu_s = 1'b0;
                grant_lsu_s = 1'b0;
            end
        end else begin
            grant_ifu_s = 1'b0;
            grant_lsu_s = 1'b0;
        end
    end

    // Ready is only ever raised toward a valid requester, so a grant is a handshake.
    assign accept_s   = grant_ifu_s | grant_lsu_s;
    assign busy_s     = (state_r == ST_ISSUE) || (state_r == ST_WAIT);
    assign timeout_s  = busy_s && (timer_r == TIMEOUT_LAST);
    assign resp_hit_s = (state_r == ST_WAIT) && mem_resp_valid;

    // Next-state logic; a real response in WAIT beats a simultaneous timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (timeout_s) begin
                    state_s = ST_RESP;
                end else if (mem_req_ready) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid || timeout_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus ownership / round-robin history updated on each handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= OWNER_IFU;
            owner_r      <= OWNER_IFU;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                owner_r      <= grant_lsu_s;
                last_grant_r <= grant_lsu_s;
            end
        end
    end

    // Capture the granted request so the bridge sees stable fields while requester inputs move on.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= 32'h0000_0000;
            wen_r   <= 1'b0;
            wdata_r <= 32'h0000_0000;
            wmask_r <= 8'h00;
        end else if (accept_s) begin
            if (grant_lsu_s) begin
                addr_r  <= lsu_addr;
                wen_r   <= lsu_wen;
                wdata_r <= lsu_wdata;
                wmask_r <= lsu_wmask;
            end else begin
                addr_r  <= ifu_addr;
                wen_r   <= 1'b0;
                wdata_r <= 32'h0000_0000;
                wmask_r <= 8'h00;
            end
        end
    end

    // Response timer: zero on entry to ISSUE, counts every ISSUE/WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= '0;
        end else if (accept_s) begin
            timer_r <= '0;
        end else if (busy_s) begin
            timer_r <= timer_r + TIMEOUT_W'(1);
        end
    end

    // Response data/error registers presented during RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
        end else if (resp_hit_s) begin
            rdata_r <= mem_rdata;
            err_r   <= 1'b0;
        end else if (timeout_s) begin
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b1;
        end
    end

    assign ifu_req_ready  = grant_ifu_s;
    assign lsu_req_ready  = grant_lsu_s;

    assign mem_req_valid  = (state_r == ST_ISSUE);
    assign mem_addr       = addr_r;
    assign mem_wen        = wen_r;
    assign mem_wdata      = wdata_r;
    assign mem_wmask      = wmask_r;

    assign ifu_resp_valid = (state_r == ST_RESP) && (owner_r == OWNER_IFU);
    assign lsu_resp_valid = (state_r == ST_RESP) && (owner_r == OWNER_LSU);
    assign ifu_rdata      = rdata_r;
    assign lsu_rdata      = rdata_r;
    assign ifu_resp_err   = ifu_resp_valid & err_r;
    assign lsu_resp_err   = lsu_resp_valid & err_r;

endmodule
